// File: rtl/dff_bist_checker_if.sv
// Pin bundle between the BIST checker and its surroundings.
// The "slave" side is the checker itself.
// The "master" side is the lab top-level: it supplies Start and the flop's Q,
// and consumes the drive and result signals.
interface dff_bist_checker_if;
    logic       Start;
    logic       Q_in;
    logic       D_out;
    logic       PreN_out;
    logic       ClrN_out;
    logic       Busy;
    logic       Done;
    logic       Pass;
    logic [2:0] ErrCount;
    logic [2:0] FailIdx;

    modport master (
        output Start, Q_in,
        input  D_out, PreN_out, ClrN_out, Busy, Done, Pass, ErrCount, FailIdx
    );

    modport slave (
        input  Start, Q_in,
        output D_out, PreN_out, ClrN_out, Busy, Done, Pass, ErrCount, FailIdx
    );
endinterface

// File: rtl/dff_bist_checker.sv
// BIST engine for one D flip-flop with active-low async preset/clear.
// It walks a fixed 6-vector table: APPLY drives a vector, then WAIT holds it
// for HOLD_CYCLES cycles, and Q is compared on the edge that ends WAIT.
// Every output is a flop, so the flop under test sees glitch-free pins.
module dff_bist_checker #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 Rst,
    dff_bist_checker_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       d_q, d_d;
    logic       pren_q, pren_d;
    logic       clrn_q, clrn_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [2:0] fail_q, fail_d;
    logic [2:0] err_next;
    logic       mismatch;

    // Drive pattern {D, PreN, ClrN} for each table index.
    function automatic logic [2:0] vec_drive(input logic [2:0] i);
        case (i)
            3'd0:    vec_drive = 3'b011;
            3'd1:    vec_drive = 3'b110;
            3'd2:    vec_drive = 3'b001;
            3'd3:    vec_drive = 3'b111;
            3'd4:    vec_drive = 3'b011;
            3'd5:    vec_drive = 3'b111;
            default: vec_drive = 3'b011;
        endcase
    endfunction

    // Q expected from a healthy flop after each vector.
    function automatic logic vec_expect(input logic [2:0] i);
        case (i)
            3'd2, 3'd3, 3'd5: vec_expect = 1'b1;
            default:          vec_expect = 1'b0;
        endcase
    endfunction

    // Next-state, next-drive and result bookkeeping for the sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        d_d      = d_q;
        pren_d   = pren_q;
        clrn_d   = clrn_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        mismatch = (bus.Q_in != vec_expect(idx_q));
        err_next = err_q;
        if (mismatch && err_q != 3'd7) begin
            err_next = err_q + 3'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.Start) begin
                    state_d                = ST_APPLY;
                    idx_d                  = 3'd0;
                    err_d                  = 3'd0;
                    fail_d                 = 3'd7;
                    pass_d                 = 1'b0;
                    busy_d                 = 1'b1;
                    {d_d, pren_d, clrn_d}  = vec_drive(3'd0);
                end
            end
            ST_APPLY: begin
                state_d = ST_WAIT;
                cnt_d   = HOLD_LOAD;
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d = err_next;
                    if (mismatch && fail_q == 3'd7) begin
                        fail_d = idx_q;
                    end
                    if (idx_q < 3'd5) begin
                        idx_d                 = idx_q + 3'd1;
                        state_d               = ST_APPLY;
                        {d_d, pren_d, clrn_d} = vec_drive(idx_q + 3'd1);
                    end else begin
                        state_d               = ST_DONE;
                        {d_d, pren_d, clrn_d} = 3'b011;
                        busy_d                = 1'b0;
                        done_d                = 1'b1;
                        pass_d                = (err_next == 3'd0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset parks the flop pins at idle drive.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            d_q     <= 1'b0;
            pren_q  <= 1'b1;
            clrn_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            pren_q  <= pren_d;
            clrn_q  <= clrn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fail_q  <= fail_d;
        end
    end

    assign bus.D_out    = d_q;
    assign bus.PreN_out = pren_q;
    assign bus.ClrN_out = clrn_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;
    assign bus.Pass     = pass_q;
    assign bus.ErrCount = err_q;
    assign bus.FailIdx  = fail_q;

endmodule

// File: doc/dff_bist_checker.md
# dff_bist_checker

Built-in self-test engine for a single positive-edge D flip-flop that has active-low asynchronous preset and clear. It drives the flip-flop's D, PreN and ClrN inputs from a fixed 6-entry vector table and samples the flip-flop's Q after each vector. It then reports a pass/fail summary. The checker and the flip-flop under test share one clock. The checker is the stimulus-and-response end of the flip-flop's pin interface and is instantiated next to the flop in lab top-levels.

## Interface
- HOLD_CYCLES, 1: cycles between the APPLY cycle and the Q sample. Legal range 1..15.
- Clk  input  1  system clock, rising edge; same clock as the flip-flop under test
- Rst  input  1  asynchronous, active-high reset
- Start  input  1  one-cycle request to run the table; honoured only in IDLE
- Q_in  input  1  Q output of the flip-flop under test
- D_out  output  1  drives the flip-flop's D input
- PreN_out  output  1  drives the flip-flop's PreN input (active-low)
- ClrN_out  output  1  drives the flip-flop's ClrN input (active-low)
- Busy  output  1  high from Start acceptance until the last sample
- Done  output  1  one-cycle pulse after the last sample
- Pass  output  1  high when the last completed run had zero mismatches
- ErrCount  output  3  mismatches in the last run, saturating at 7
- FailIdx  output  3  index of the first failing vector; 7 if none

## Operation
- The clock is Clk. Reset is asynchronous and active-high; the reset port is Rst.
- Vector table, as index: D, PreN, ClrN -> expected Q:
  - 0: 0,1,1 -> 0
  - 1: 1,1,0 -> 0 (clear)
  - 2: 0,0,1 -> 1 (preset)
  - 3: 1,1,1 -> 1
  - 4: 0,1,1 -> 0
  - 5: 1,1,1 -> 1
- States:
  - IDLE
  - APPLY: exactly 1 cycle
  - WAIT: HOLD_CYCLES cycles, with a 4-bit down-counter
  - DONE: exactly 1 cycle
- IDLE + Start:
  - Go to APPLY with idx=0.
  - Clear ErrCount to 0, FailIdx to 7 and Pass to 0.
  - Load D_out/PreN_out/ClrN_out with vector 0 on the same edge.
- APPLY -> WAIT on the next edge. The flip-flop under test captures D on this edge.
- WAIT: on the edge that ends the last WAIT cycle, compare Q_in with the expected value of vector idx.
  - On mismatch, increment ErrCount, saturating at 7.
  - If FailIdx==7, load FailIdx with idx.
  - If idx<5: idx+1, go to APPLY and load the next vector on the same edge.
  - If idx==5: go to DONE and restore the idle drive D_out=0, PreN_out=1, ClrN_out=1.
- DONE: Done=1; Pass = (ErrCount==0), including the final vector's result. Go to IDLE on the next edge.
- Pass, ErrCount and FailIdx hold until the next accepted Start.
- Start is ignored in APPLY, WAIT and DONE. It is not queued.
- Outputs are registered and depend on state only (Moore outputs). Busy=1 in APPLY and WAIT.

## Timing
- Reset values, forced immediately on Rst assertion, independent of Clk:
  - Outputs: D_out=0, PreN_out=1, ClrN_out=1, Busy=0, Done=0, Pass=0, ErrCount=0, FailIdx=7.
  - State IDLE, idx=0.
- Reset mid-run aborts the run with no Done pulse and no partial results.
- Let edge t0 be the edge that accepts Start.
- Vector k outputs change at edge t0 + k·(1+HOLD_CYCLES).
- The flip-flop under test captures vector k one edge later.
- Q_in for vector k is sampled at edge t0 + (k+1)·(1+HOLD_CYCLES).
- Busy is high for 6·(1+HOLD_CYCLES) cycles.
- Done is high in the following cycle. Pass is valid from that same cycle.
- A Start sampled in the Done-high cycle is ignored. The earliest accepted restart is the cycle after Done.
- Q_in must be stable at the sample edge. With HOLD_CYCLES≥1, the flop's output has had at least one full cycle to settle.

## Test plan
- Correct flip-flop, HOLD_CYCLES=1, Start at t0 -> Busy for 12 cycles, Done pulse at t0+12, Pass=1, ErrCount=0, FailIdx=7. The D/PreN/ClrN sequence matches the table.
- Q_in tied 0 -> vectors 2, 3 and 5 fail: ErrCount=3, FailIdx=2, Pass=0.
- Q_in tied 1 -> vectors 0, 1 and 4 fail: ErrCount=3, FailIdx=0, Pass=0.
- Start re-pulsed at t0+4 -> ignored; Done still at t0+12 and the results are unchanged. Start one cycle after Done -> accepted; ErrCount and FailIdx clear on that edge.
- Rst asserted mid-cycle during vector 3 -> outputs take their reset values before the next Clk edge and Busy=0. There is no Done. After release, a fresh Start gives the full run.
- HOLD_CYCLES=3 with a correct flip-flop -> each vector lasts 4 cycles, Done at t0+24, Pass=1.
